// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame-checker state encoding,
// parity-type codes and the expected-parity rule.
package uart_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        START  = S_START,
        DATA   = S_DATA,
        PARITY = S_PARITY,
        STOP   = S_STOP
    } state_t;

    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    // acc is the running XOR of the data bits received so far.
    function automatic logic exp_parity(input logic [1:0] typ, input logic acc);
        case (typ)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sat_cnt.sv
// Saturating up-counter with a clear that wins over the held value but still
// honours a same-cycle increment (clear + inc loads 1).
module uart_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= {{(CNT_W-1){1'b0}}, inc};
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: follows the sampler's bit stream, validates start,
// parity and stop bits, and keeps sticky flags plus saturating error counters.
module uart_rx_frame_chk
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int STOP_W  = 1,
    parameter int PRESC_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Frame_Start,
    input  logic               Sampled_Bit,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic [PRESC_W-1:0] Edge_Cnt,
    input  logic               PAR_EN,
    input  logic [1:0]         PAR_TYP,
    input  logic               Err_Clr,
    output logic               Frame_Done,
    output logic               Strt_Err,
    output logic               Par_Err,
    output logic               Stp_Err,
    output logic [CNT_W-1:0]   Par_Err_Cnt,
    output logic [CNT_W-1:0]   Frm_Err_Cnt
);

    localparam int               BC_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(DATA_W - 1);
    localparam logic             LAST_STOP = (STOP_W == 2);
    localparam logic [PRESC_W:0] STRB_OFS  = 2;

    state_t          r_state, w_state_nxt;
    logic [BC_W-1:0] r_bit_cnt;
    logic            r_stop_cnt;
    logic            r_par_acc;
    logic            r_par_en;
    logic [1:0]      r_par_typ;
    logic            r_frm_par_err;
    logic            r_frm_ss_err;
    logic            r_frame_done;
    logic            r_par_inc;
    logic            r_frm_inc;
    logic            r_strt_err;
    logic            r_par_err;
    logic            r_stp_err;

    logic            w_strobe;
    logic            w_start_fail;
    logic            w_par_fail;
    logic            w_stop_fail;
    logic            w_last_stop;

    // One extra bit keeps (Prescale>>1)+2 from wrapping at the top of the range.
    assign w_strobe = ({1'b0, Edge_Cnt} == ({1'b0, Prescale >> 1} + STRB_OFS));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_start_fail = 1'b0;
        w_par_fail   = 1'b0;
        w_stop_fail  = 1'b0;
        w_last_stop  = 1'b0;
        if (Frame_Start) begin
            w_state_nxt = START;
        end else if (w_strobe) begin
            case (r_state)
                START: begin
                    w_start_fail = Sampled_Bit;
                    w_state_nxt  = DATA;
                end
                DATA: begin
                    if (r_bit_cnt == LAST_BIT)
                        w_state_nxt = r_par_en ? PARITY : STOP;
                end
                PARITY: begin
                    w_par_fail  = (Sampled_Bit != exp_parity(r_par_typ, r_par_acc));
                    w_state_nxt = STOP;
                end
                STOP: begin
                    w_stop_fail = ~Sampled_Bit;
                    if (r_stop_cnt == LAST_STOP) begin
                        w_last_stop = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_bit_cnt     <= '0;
            r_stop_cnt    <= 1'b0;
            r_par_acc     <= 1'b0;
            r_par_en      <= 1'b0;
            r_par_typ     <= PAR_EVEN;
            r_frm_par_err <= 1'b0;
            r_frm_ss_err  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_par_inc     <= 1'b0;
            r_frm_inc     <= 1'b0;
            r_strt_err    <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
        end else begin
            // Frame_Start also serves as the abort: the old frame's per-frame
            // results are dropped, sticky flags are left alone.
            if (Frame_Start) begin
                r_bit_cnt     <= '0;
                r_stop_cnt    <= 1'b0;
                r_par_acc     <= 1'b0;
                r_par_en      <= PAR_EN;
                r_par_typ     <= PAR_TYP;
                r_frm_par_err <= 1'b0;
                r_frm_ss_err  <= 1'b0;
            end else if (w_strobe) begin
                if (r_state == DATA) begin
                    r_par_acc <= r_par_acc ^ Sampled_Bit;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (r_state == STOP)
                    r_stop_cnt <= ~r_stop_cnt;
                r_frm_par_err <= r_frm_par_err | w_par_fail;
                r_frm_ss_err  <= r_frm_ss_err | w_start_fail | w_stop_fail;
            end
            // Counters bump on the Frame_Done cycle itself, so a coincident
            // Err_Clr loads the increment value.
            r_frame_done <= w_last_stop;
            r_par_inc    <= w_last_stop & r_frm_par_err;
            r_frm_inc    <= w_last_stop & (r_frm_ss_err | w_stop_fail);
            r_strt_err   <= (r_strt_err & ~Err_Clr) | w_start_fail;
            r_par_err    <= (r_par_err  & ~Err_Clr) | w_par_fail;
            r_stp_err    <= (r_stp_err  & ~Err_Clr) | w_stop_fail;
        end
    end

    uart_sat_cnt #(.CNT_W(CNT_W)) u_par_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (r_par_inc),
        .clr   (Err_Clr),
        .count (Par_Err_Cnt)
    );

    uart_sat_cnt #(.CNT_W(CNT_W)) u_frm_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (r_frm_inc),
        .clr   (Err_Clr),
        .count (Frm_Err_Cnt)
    );

    assign Frame_Done = r_frame_done;
    assign Strt_Err   = r_strt_err;
    assign Par_Err    = r_par_err;
    assign Stp_Err    = r_stp_err;

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Scoreboard bench for uart_rx_frame_chk: a frame-level driver predicts each
// completed frame's flags and counters; a monitor checks them on Frame_Done.
module tb_uart_rx_frame_chk;
    import uart_pkg::*;

    localparam int DATA_W  = 8;
    localparam int STOP_W  = 2;
    localparam int PRESC_W = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               CLK;
    logic               RST;
    logic               Frame_Start;
    logic               Sampled_Bit;
    logic [PRESC_W-1:0] Prescale;
    logic [PRESC_W-1:0] Edge_Cnt;
    logic               PAR_EN;
    logic [1:0]         PAR_TYP;
    logic               Err_Clr;
    logic               Frame_Done;
    logic               Strt_Err;
    logic               Par_Err;
    logic               Stp_Err;
    logic [CNT_W-1:0]   Par_Err_Cnt;
    logic [CNT_W-1:0]   Frm_Err_Cnt;

    uart_rx_frame_chk #(
        .DATA_W (DATA_W),
        .STOP_W (STOP_W),
        .PRESC_W(PRESC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Frame_Start(Frame_Start),
        .Sampled_Bit(Sampled_Bit),
        .Prescale   (Prescale),
        .Edge_Cnt   (Edge_Cnt),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Err_Clr    (Err_Clr),
        .Frame_Done (Frame_Done),
        .Strt_Err   (Strt_Err),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err),
        .Par_Err_Cnt(Par_Err_Cnt),
        .Frm_Err_Cnt(Frm_Err_Cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic strt;
        logic par;
        logic stp;
        int   pcnt;
        int   fcnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pushed = 0;
    int   n_done   = 0;
    int   strobe_pos;

    // Reference model state: sticky flags and counters as the spec defines them.
    logic m_strt, m_par, m_stp;
    int   m_pcnt, m_fcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_parity(input logic [DATA_W-1:0] d, input logic [1:0] t);
        int ones = $countones(d);
        case (t)
            PAR_EVEN: return (ones % 2) == 1;
            PAR_ODD:  return (ones % 2) == 0;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic model_clear();
        m_strt = 0; m_par = 0; m_stp = 0; m_pcnt = 0; m_fcnt = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_strt_err"}, Strt_Err, m_strt);
        check({tag, "_par_err"},  Par_Err,  m_par);
        check({tag, "_stp_err"},  Stp_Err,  m_stp);
        check({tag, "_par_cnt"},  Par_Err_Cnt, m_pcnt);
        check({tag, "_frm_cnt"},  Frm_Err_Cnt, m_fcnt);
    endtask

    // One bit period; kind: 0 start, 1 data, 2 parity, 3 stop.
    // Off-strobe cycles carry random line values and random PAR_EN/PAR_TYP.
    task automatic send_bit(input logic b, input int kind, input logic fail,
                            input bit clr_at, input bit clr_after);
        for (int e = 0; e < int'(Prescale); e++) begin
            @(negedge CLK);
            if (e == strobe_pos + 1) check_state("bit");
            Frame_Start = 1'b0;
            Edge_Cnt    = PRESC_W'(e);
            Sampled_Bit = (e == strobe_pos) ? b : 1'($urandom);
            PAR_EN      = 1'($urandom);
            PAR_TYP     = 2'($urandom);
            Err_Clr     = (e == strobe_pos && clr_at) || (e == strobe_pos + 1 && clr_after);
            if (e == strobe_pos) begin
                if (clr_at) model_clear();
                if (kind == 0) m_strt = m_strt | fail;
                if (kind == 2) m_par  = m_par  | fail;
                if (kind == 3) m_stp  = m_stp  | fail;
            end
        end
    endtask

    // abort_at: -1 completes the frame; 0..8 stops after that many data bits.
    task automatic send_frame(input logic [DATA_W-1:0] data, input logic pen,
                              input logic [1:0] ptyp, input logic sbit, input logic pbit,
                              input logic st0, input logic st1, input int abort_at,
                              input bit clr_start, input bit clr_done);
        logic pfail, tfail;
        exp_t e;
        @(negedge CLK);
        Prescale    = PRESC_W'($urandom_range(8, 20));
        strobe_pos  = int'(Prescale >> 1) + 2;
        Frame_Start = 1'b1;
        PAR_EN      = pen;
        PAR_TYP     = ptyp;
        Edge_Cnt    = '0;
        Err_Clr     = 1'b0;
        Sampled_Bit = 1'b1;
        send_bit(sbit, 0, sbit, clr_start, 1'b0);
        for (int i = 0; i < DATA_W; i++) begin
            if (i == abort_at) return;
            send_bit(data[i], 1, 1'b0, 1'b0, 1'b0);
        end
        if (abort_at == DATA_W) return;
        pfail = pen && (pbit != ref_parity(data, ptyp));
        if (pen) send_bit(pbit, 2, pfail, 1'b0, 1'b0);
        send_bit(st0, 3, !st0, 1'b0, 1'b0);
        tfail  = sbit | !st0 | !st1;
        e.strt = m_strt;
        e.par  = m_par;
        e.stp  = m_stp | !st1;
        e.pcnt = clr_done ? int'(pfail) : sat(m_pcnt + int'(pfail));
        e.fcnt = clr_done ? int'(tfail) : sat(m_fcnt + int'(tfail));
        sb.push_back(e);
        n_pushed++;
        send_bit(st1, 3, !st1, 1'b0, clr_done);
        m_pcnt = e.pcnt;
        m_fcnt = e.fcnt;
        if (clr_done) begin
            m_strt = 0; m_par = 0; m_stp = 0;
        end
    endtask

    task automatic clear_idle();
        @(negedge CLK);
        Frame_Start = 1'b0;
        Edge_Cnt    = '0;
        Err_Clr     = 1'b1;
        model_clear();
        @(negedge CLK);
        Err_Clr = 1'b0;
        check_state("clr");
    endtask

    // Monitor: pops one prediction per Frame_Done pulse.
    always begin
        @(posedge CLK);
        #1;
        if (RST === 1'b1 && Frame_Done === 1'b1) begin
            n_done++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: Frame_Done=1 with no frame pending at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("done_strt_err", Strt_Err, mon_e.strt);
                check("done_par_err",  Par_Err,  mon_e.par);
                check("done_stp_err",  Stp_Err,  mon_e.stp);
                @(posedge CLK);
                #1;
                check("done_pulse_width", Frame_Done, 1'b0);
                check("done_par_cnt", Par_Err_Cnt, mon_e.pcnt);
                check("done_frm_cnt", Frm_Err_Cnt, mon_e.fcnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic              pen;
        logic [1:0]        pt;
        RST = 1'b0; Frame_Start = 1'b0; Sampled_Bit = 1'b1; Prescale = 8'd8;
        Edge_Cnt = '0; PAR_EN = 1'b0; PAR_TYP = PAR_EVEN; Err_Clr = 1'b0;
        strobe_pos = 6;
        model_clear();
        repeat (3) @(negedge CLK);
        check("rst_frame_done", Frame_Done, 1'b0);
        check_state("rst");
        RST = 1'b1;

        // Directed: clean frame, then two bad-parity frames.
        send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 0);
        send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 0);
        send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 0);
        clear_idle();
        // Second stop bit low.
        send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0, 0);
        clear_idle();
        // Mark and space on data 0x00 with parity bit 1.
        send_frame(8'h00, 1'b1, PAR_MARK,  1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 0);
        send_frame(8'h00, 1'b1, PAR_SPACE, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 0);
        clear_idle();
        // Saturation, then Err_Clr coincident with Frame_Done.
        repeat (5) send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 0);
        send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 1);
        // Err_Clr on a failing start strobe: the set wins.
        send_frame(8'h3C, 1'b0, PAR_ODD, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1, 0);
        // Abort mid-DATA, then a clean frame.
        send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b1, 1'b0, 1'b1, 1'b1, 3, 0, 0);
        send_frame(8'h96, 1'b1, PAR_ODD,  1'b0, 1'b1, 1'b1, 1'b1, -1, 0, 0);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            d   = DATA_W'($urandom);
            pen = 1'($urandom);
            pt  = 2'($urandom);
            send_frame(d, pen, pt, ($urandom_range(0, 5) == 0),
                       ref_parity(d, pt) ^ ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1,
                       ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 5) == 0) clear_idle();
        end

        // Async reset while in PARITY, with flags and counters non-zero.
        send_frame(8'h3C, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0, 0);
        send_frame(8'h5A, 1'b1, PAR_ODD,  1'b1, 1'b0, 1'b1, 1'b1, DATA_W, 0, 0);
        @(negedge CLK);
        Edge_Cnt = '0;
        #2;
        RST = 1'b0;
        #1;
        model_clear();
        check("midrst_frame_done", Frame_Done, 1'b0);
        check_state("midrst");
        @(negedge CLK);
        RST = 1'b1;
        send_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0, 0);

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", sb.size(), 0);
        check("done_count", n_done, n_pushed);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
